life_generation_controller: RTL

Sequences Game of Life generations for the 16x16 toroidal cell grid driven to the VGA renderer. The block holds two 256-bit cell banks, one for display and one for the next generation. The display bank is exposed through a zero-latency read port indexed by the renderer's `cell_index`. During vertical blanking the block computes the next generation into the shadow bank one cell per clock, then swaps the banks, so the displayed frame never shows a partially updated grid.

---
 rtl/life_generation_controller.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/life_generation_controller.sv
// Double-buffered 16x16 toroidal Game of Life engine: the renderer reads the display bank
// while the next generation is built into the shadow bank during vertical blanking.
module life_generation_controller #(
  parameter int unsigned  FRAMES_PER_GEN = 30,
  parameter logic [255:0] SEED = (256'h1 << 1) | (256'h1 << 18) | (256'h1 << 32) |
                                 (256'h1 << 33) | (256'h1 << 34)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        run,
  input  logic        step,
  input  logic        load,
  input  logic [7:0]  rd_index,
  output logic        rd_alive,
  output logic        busy,
  output logic        swap,
  output logic [15:0] generation,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_SWAP    = 2'd2
  } state_t;

  localparam logic [7:0] LP_LAST_FRAME = 8'(FRAMES_PER_GEN - 1);

  state_t        r_state;
  logic [255:0]  r_bank0;
  logic [255:0]  r_bank1;
  logic          r_bank_sel;
  logic [7:0]    r_frame_cnt;
  logic [7:0]    r_cell_idx;
  logic          r_step_pending;
  logic          r_load_pending;
  logic          r_busy;
  logic          r_swap;
  logic [15:0]   r_generation;

  logic [255:0]  w_display;
  logic [3:0]    w_x;
  logic [3:0]    w_y;
  logic [3:0]    w_xm;
  logic [3:0]    w_xp;
  logic [3:0]    w_ym;
  logic [3:0]    w_yp;
  logic [3:0]    w_count;
  logic          w_next;

  // Bank select names the displayed bank; the other one is the shadow being written.
  assign w_display = r_bank_sel ? r_bank1 : r_bank0;
  assign rd_alive  = w_display[rd_index];

  assign w_x  = r_cell_idx[3:0];
  assign w_y  = r_cell_idx[7:4];
  assign w_xm = w_x - 4'd1;
  assign w_xp = w_x + 4'd1;
  assign w_ym = w_y - 4'd1;
  assign w_yp = w_y + 4'd1;

  // 4-bit coordinate arithmetic wraps at 16, giving the toroidal neighbourhood for free.
  assign w_count = 4'(w_display[{w_ym, w_xm}]) + 4'(w_display[{w_ym, w_x}]) +
                   4'(w_display[{w_ym, w_xp}]) + 4'(w_display[{w_y,  w_xm}]) +
                   4'(w_display[{w_y,  w_xp}]) + 4'(w_display[{w_yp, w_xm}]) +
                   4'(w_display[{w_yp, w_x}])  + 4'(w_display[{w_yp, w_xp}]);

  assign w_next = (w_count == 4'd3) | (w_display[r_cell_idx] & (w_count == 4'd2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_bank0        <= SEED;
      r_bank1        <= SEED;
      r_bank_sel     <= 1'b0;
      r_frame_cnt    <= 8'd0;
      r_cell_idx     <= 8'd0;
      r_step_pending <= 1'b0;
      r_load_pending <= 1'b0;
      r_busy         <= 1'b0;
      r_swap         <= 1'b0;
      r_generation   <= 16'd0;
    end else begin
      r_swap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_tick) begin
            if (r_load_pending) begin
              if (r_bank_sel) r_bank1 <= SEED;
              else            r_bank0 <= SEED;
              r_generation   <= 16'd0;
              r_frame_cnt    <= 8'd0;
              r_load_pending <= 1'b0;
              r_step_pending <= 1'b0;
            end else if (run) begin
              if (r_frame_cnt == LP_LAST_FRAME) begin
                r_frame_cnt <= 8'd0;
                r_cell_idx  <= 8'd0;
                r_busy      <= 1'b1;
                r_state     <= S_COMPUTE;
              end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
              end
            end else begin
              r_frame_cnt <= 8'd0;
              if (r_step_pending) begin
                r_step_pending <= 1'b0;
                r_cell_idx     <= 8'd0;
                r_busy         <= 1'b1;
                r_state        <= S_COMPUTE;
              end
            end
          end else if (!run) begin
            r_frame_cnt <= 8'd0;
          end
        end
        S_COMPUTE: begin
          if (r_bank_sel) r_bank0[r_cell_idx] <= w_next;
          else            r_bank1[r_cell_idx] <= w_next;
          r_cell_idx <= r_cell_idx + 8'd1;
          if (r_cell_idx == 8'd255) r_state <= S_SWAP;
        end
        S_SWAP: begin
          r_bank_sel   <= ~r_bank_sel;
          r_generation <= r_generation + 16'd1;
          r_busy       <= 1'b0;
          r_swap       <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Fresh pulses win over same-cycle consumption so no request is lost.
      if (step) r_step_pending <= 1'b1;
      if (load) r_load_pending <= 1'b1;
    end
  end

  assign busy       = r_busy;
  assign swap       = r_swap;
  assign generation = r_generation;
  assign dbg_state  = r_state;

endmodule
